// File: rtl/aes_ctr_seq.sv
// rtl/aes_ctr_seq.sv - constant-time slice-serial AES CTR counter sequencer
module aes_ctr_seq #(
  parameter int SliceSize = 16,
  parameter int NumSlices = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            ctr_load_i,
  input  logic [SliceSize*NumSlices-1:0]  ctr_load_data_i,
  input  logic                            incr_req_i,
  output logic                            incr_ready_o,
  output logic                            incr_done_o,
  output logic                            ctr_wrap_o,
  output logic [SliceSize*NumSlices-1:0]  ctr_o,
  output logic [$clog2(NumSlices)-1:0]    ctr_slice_idx_o,
  output logic                            busy_o,
  input  logic                            mr_err_i,
  output logic                            alert_o
);

  localparam int IdxW = $clog2(NumSlices);

  // Pairwise Hamming distance >= 3 so a single upset never lands on another valid state.
  typedef enum logic [5:0] {
    ST_IDLE  = 6'b001110,
    ST_INCR  = 6'b110101,
    ST_ERROR = 6'b101000
  } state_e;

  state_e                              state_q;
  logic [NumSlices-1:0][SliceSize-1:0] ctr_q;
  logic [IdxW-1:0]                     idx_q;
  logic                                carry_q;
  logic                                done_q;
  logic                                wrap_q;

  logic [SliceSize:0] slice_sum;
  logic               last_slice;
  logic               is_idle;
  logic               is_incr;

  // Shared adder: the slice under the cursor plus the carry rippled in from the previous cycle.
  always_comb begin
    slice_sum = {1'b0, ctr_q[idx_q]} + {{SliceSize{1'b0}}, carry_q};
  end

  assign last_slice = (idx_q == IdxW'(NumSlices - 1));
  assign is_idle    = (state_q == ST_IDLE);
  assign is_incr    = (state_q == ST_INCR);

  // Sequencer FSM and counter storage; every slice is swept even once the carry has died out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mr_err_i) begin
            state_q <= ST_ERROR;
          end else if (ctr_load_i) begin
            ctr_q <= ctr_load_data_i;
          end else if (incr_req_i) begin
            state_q <= ST_INCR;
            carry_q <= 1'b1;
            idx_q   <= '0;
          end
        end
        ST_INCR: begin
          // A load mid-sweep would tear the counter, so it is treated as fatal.
          if (mr_err_i || ctr_load_i) begin
            state_q <= ST_ERROR;
          end else begin
            ctr_q[idx_q] <= slice_sum[SliceSize-1:0];
            carry_q      <= slice_sum[SliceSize];
            idx_q        <= idx_q + IdxW'(1);
            if (last_slice) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              wrap_q  <= slice_sum[SliceSize];
            end
          end
        end
        // ERROR and every invalid encoding collapse into the terminal error state.
        default: begin
          state_q <= ST_ERROR;
        end
      endcase
    end
  end

  assign incr_ready_o    = is_idle & ~ctr_load_i;
  assign busy_o          = is_incr;
  assign alert_o         = ~is_idle & ~is_incr;
  assign incr_done_o     = done_q;
  assign ctr_wrap_o      = wrap_q;
  assign ctr_o           = ctr_q;
  assign ctr_slice_idx_o = idx_q;

endmodule

// File: doc/aes_ctr_seq.md
# aes_ctr_seq

Slice-serial sequencer and owner of the 128-bit AES CTR-mode counter register. It accepts a single-cycle load of a new counter value, and increments requested via a ready/valid handshake. It performs every increment in constant time by sweeping all counter slices LSB-first through one shared SliceSize-bit adder with carry. It sits between the AES control FSM and the CTR datapath, and escalates any sequencing fault to a terminal alert state.

## Interface
- SliceSize, 16: width of one counter slice in bits (adder width).
- NumSlices, 8: number of slices; counter width = SliceSize*NumSlices = 128.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, reset asynchronous and active-low.
- ctr_load_i  in  1  write ctr_load_data_i into the counter (single-cycle strobe).
- ctr_load_data_i  in  128  new counter value, big-endian integer (bit 127 = MSB).
- incr_req_i  in  1  increment request (valid).
- incr_ready_o  out  1  sequencer accepts a request this cycle.
- incr_done_o  out  1  one-cycle pulse: increment completed, ctr_o updated.
- ctr_wrap_o  out  1  one-cycle pulse with incr_done_o when the counter wrapped 2^128-1 -> 0.
- ctr_o  out  128  current counter value.
- ctr_slice_idx_o  out  3  slice currently processed (0 = least significant).
- busy_o  out  1  increment in progress.
- mr_err_i  in  1  external multi-rail/control-signal error.
- alert_o  out  1  fatal error, sticky until reset.

## Operation
- States: IDLE, INCR, ERROR. Sparse state encoding with Hamming distance >= 3; any invalid encoding is treated as ERROR.
- IDLE:
  - ctr_load_i=1 writes ctr_o <= ctr_load_data_i. Load has priority over a request.
  - incr_ready_o = (state==IDLE) & ~ctr_load_i.
  - On incr_req_i & incr_ready_o: set carry <= 1, set idx <= 0, go to INCR.
- INCR, one slice per cycle:
  - slice[idx] <= slice[idx] + carry, taken mod 2^SliceSize.
  - carry <= carry-out.
  - idx increments.
  - All NumSlices slices are always processed, even after carry becomes 0. Timing is data-independent.
  - After the cycle with idx = NumSlices-1: go to IDLE, assert incr_done_o for one cycle, and assert ctr_wrap_o = final carry-out in the same cycle.
- incr_req_i asserted during INCR is ignored (ready low). It is not an error.
- ctr_load_i during INCR is a protocol violation and goes to ERROR.
- mr_err_i=1 in any state, or an invalid state encoding, goes to ERROR.
- ERROR is terminal until rst_ni:
  - alert_o=1, incr_ready_o=0, busy_o=0.
  - incr_done_o=0, ctr_wrap_o=0.
  - ctr_o is frozen at its value on entry, partial slice updates included. No load or increment takes effect.
- busy_o = (state==INCR). ctr_slice_idx_o = idx.

## Timing
- Reset values:
  - state=IDLE, so incr_ready_o=1 unless ctr_load_i is high.
  - ctr_o=0, ctr_slice_idx_o=0.
  - incr_done_o=0, ctr_wrap_o=0, busy_o=0, alert_o=0.
- Reset asserted mid-INCR aborts immediately. Outputs take their reset values asynchronously.
- Request accepted at cycle T:
  - busy_o=1 in T+1..T+NumSlices, with ctr_slice_idx_o = 0..7 respectively.
  - Slice k is updated at the end of cycle T+1+k.
- Cycle T+9: incr_done_o=1 and ctr_wrap_o valid, ctr_o holds the final value, incr_ready_o=1. Latency accept-to-done is 9 cycles.
- Back-to-back: a request held high is accepted again in T+9. Throughput is one increment per 9 cycles.
- Load at cycle T: ctr_o shows the new value in T+1.
- Error entry is registered. alert_o rises the cycle after mr_err_i or a load-during-INCR is sampled.
- incr_done_o and ctr_wrap_o are registered, single-cycle pulses. They never coincide with busy_o=1.

## Test plan
- Reset, then load 0x0000...0000_FFFF, then request. Expect done at T+9 and ctr_o=0x0000...0001_0000, wrap=0, slice_idx sequence 0..7 while busy.
- Load all-ones, then request. Expect ctr_o=0 at done, ctr_wrap_o=1 for exactly one cycle, and busy for 8 cycles (constant time).
- Hold incr_req_i high for 3 increments from 0. Expect dones at T+9, T+18, T+27, ctr_o=3, with ready low during each busy window.
- Assert ctr_load_i and incr_req_i in the same IDLE cycle with data=0x5. Expect ready=0, ctr_o=5, no increment started.
- Pulse ctr_load_i while busy at idx=3. Expect alert_o=1 next cycle and ready/done permanently low. ctr_o keeps the partially updated value until rst_ni.
- Assert mr_err_i in IDLE, then deassert. Expect alert sticky, requests ignored. Drop rst_ni mid-stream: all outputs return to reset values asynchronously, and ready returns to 1.
